// File: rtl/imem_loader.sv
`default_nettype none
// =============================================================================
// imem_loader -- receives a length-prefixed, checksummed byte stream, packs it
// MSB-first into 32-bit words and writes them to instruction memory.
// Revision: 1.0
// =============================================================================
module imem_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] count_q, count_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  cksum_q, cksum_d;
    logic [15:0] words_loaded_q, words_loaded_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        core_hold_q, core_hold_d;

    logic        byte_acc;
    logic [15:0] hdr_n;
    logic [31:0] word_next;

    assign rx_ready  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
    assign byte_acc  = rx_valid && rx_ready;
    assign hdr_n     = {count_q[15:8], rx_data};
    assign word_next = {word_q[23:0], rx_data};

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        count_d        = count_q;
        word_d         = word_q;
        cksum_d        = cksum_q;
        words_loaded_d = words_loaded_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d        = S_HDR;
                    byte_cnt_d     = 2'd0;
                    cksum_d        = 8'd0;
                    words_loaded_d = 16'd0;
                end
            end
            S_HDR: begin
                if (byte_acc) begin
                    if (byte_cnt_q == 2'd0) begin
                        count_d[15:8] = rx_data;
                        byte_cnt_d    = 2'd1;
                    end else begin
                        count_d    = hdr_n;
                        byte_cnt_d = 2'd0;
                        if ((hdr_n == 16'd0) || (32'(hdr_n) > 32'(MAX_WORDS)))
                            state_d = S_ERR;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_acc) begin
                    word_d     = word_next;
                    cksum_d    = cksum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Write is registered, so it lands the cycle after the 4th byte
                    // while the next byte can already be taken.
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d        = 1'b1;
                        wr_addr_d      = {16'd0, words_loaded_q};
                        wr_data_d      = word_next;
                        words_loaded_d = words_loaded_q + 16'd1;
                        if ((words_loaded_q + 16'd1) == count_q)
                            state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (byte_acc)
                    state_d = (rx_data == cksum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERR);
        core_hold_d = busy_d || (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= 2'd0;
            count_q        <= 16'd0;
            word_q         <= 32'd0;
            cksum_q        <= 8'd0;
            words_loaded_q <= 16'd0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= 32'd0;
            wr_data_q      <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            core_hold_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            count_q        <= count_d;
            word_q         <= word_d;
            cksum_q        <= cksum_d;
            words_loaded_q <= words_loaded_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            core_hold_q    <= core_hold_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign core_hold    = core_hold_q;
    assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// =============================================================================
// tb_imem_loader -- table, hand-written and randomized loads against a
// stream-level reference model of the loader.
// Revision: 1.0
// =============================================================================
module tb_imem_loader;

    localparam int MAXW = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Stream-level view: bytes accepted since start, which of them closes a word
    logic [31:0] words[$];
    logic [31:0] got_data[$];
    int acc_cnt = 0;
    int cur_n   = 0;
    int wr_seen = 0;
    bit exp_wr  = 1'b0;

    always @(posedge clk) begin
        if (rx_valid && rx_ready) begin
            exp_wr = (acc_cnt >= 2) && (acc_cnt < 2 + 4 * cur_n) && (((acc_cnt - 2) % 4) == 3);
            acc_cnt++;
        end else begin
            exp_wr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("wr_en_strobe", 64'(wr_en), 64'(exp_wr));
            if (wr_en) begin
                chk("wr_addr", 64'(wr_addr), 64'(wr_seen));
                chk("words_loaded_at_write", 64'(words_loaded), 64'(wr_seen + 1));
                got_data.push_back(wr_data);
                wr_seen++;
            end
        end
    end

    function automatic bit model_done(input int n, input int delta);
        return (n >= 1) && (n <= MAXW) && (delta == 0);
    endfunction

    function automatic int model_words(input int n);
        return ((n >= 1) && (n <= MAXW)) ? n : 0;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
        chk({tag, "_flags"}, 64'({busy, done, error, core_hold, rx_ready}), 64'd0);
    endtask

    task automatic pulse_start(input bit fresh);
        @(negedge clk);
        rx_valid = 1'b0;
        start = 1'b1;
        if (fresh) begin
            acc_cnt = 0;
            wr_seen = 0;
            got_data.delete();
        end
        @(negedge clk);
        start = 1'b0;
        if (fresh) begin
            chk("start_flags", 64'({busy, done, error, core_hold, rx_ready}), 64'b10011);
            chk("start_words_loaded", 64'(words_loaded), 64'd0);
        end
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int gap;
        int t;
        gap = $urandom_range(0, maxgap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout got=0 expected=1");
        end
        @(posedge clk);
    endtask

    task automatic run_load(input logic [15:0] n, input logic [7:0] delta, input int maxgap,
                            input int start_mid, input bit exp_done, input int exp_words);
        logic [7:0] cks;
        logic [7:0] b;
        bit hdr_bad;
        pulse_start(1'b1);
        cur_n = int'(n);
        send(n[15:8], maxgap);
        send(n[7:0], maxgap);
        hdr_bad = (n == 16'd0) || (int'(n) > MAXW);
        cks = 8'd0;
        if (hdr_bad) begin
            @(negedge clk);
            rx_valid = 1'b0;
            chk("hdr_err_immediate", 64'({error, rx_ready, busy}), 64'b100);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                rx_valid = 1'b1;
                rx_data = 8'($urandom);
            end
        end else begin
            for (int w = 0; w < int'(n); w++) begin
                for (int k = 3; k >= 0; k--) begin
                    if (start_mid == w * 4 + (3 - k))
                        pulse_start(1'b0);
                    b = words[w][8*k +: 8];
                    send(b, maxgap);
                    cks = cks + b;
                end
            end
            send(8'(cks + delta), maxgap);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("done", 64'(done), 64'(exp_done));
        chk("error", 64'(error), 64'(!exp_done));
        chk("core_hold", 64'(core_hold), 64'(!exp_done));
        chk("busy_rx_ready_end", 64'({busy, rx_ready}), 64'd0);
        chk("words_loaded", 64'(words_loaded), 64'(exp_words));
        chk("write_count", 64'(got_data.size()), 64'(exp_words));
        for (int i = 0; i < exp_words && i < got_data.size(); i++)
            chk("wr_data", 64'(got_data[i]), 64'(words[i]));
        if (exp_words > 0) begin
            chk("wr_addr_hold", 64'(wr_addr), 64'(exp_words - 1));
            chk("wr_data_hold", 64'(wr_data), 64'(words[exp_words-1]));
        end
    endtask

    typedef struct {
        logic [15:0] n;
        logic [7:0]  delta;
        int          maxgap;
        int          start_mid;
        bit          exp_done;
        int          exp_words;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        // Nominal stream, back-to-back bytes, then the same with a bad checksum
        words.delete();
        words.push_back(32'h20080005);
        words.push_back(32'h08000000);
        run_load(16'd2, 8'd0, 0, -1, 1'b1, 2);
        run_load(16'd2, 8'd1, 0, -1, 1'b0, 2);

        tbl[0] = '{16'd1,      8'd0,   0, -1, 1'b1, 1};
        tbl[1] = '{16'd3,      8'd1,   2, -1, 1'b0, 3};
        tbl[2] = '{16'h0000,   8'd0,   0, -1, 1'b0, 0};
        tbl[3] = '{16'h0101,   8'd0,   1, -1, 1'b0, 0};
        tbl[4] = '{16'hFFFF,   8'd0,   0, -1, 1'b0, 0};
        tbl[5] = '{16'd256,    8'd0,   0, -1, 1'b1, 256};
        tbl[6] = '{16'd4,      8'd0,   1,  6, 1'b1, 4};
        tbl[7] = '{16'd5,      8'hFF,  0,  0, 1'b0, 5};
        for (int v = 0; v < 8; v++) begin
            words.delete();
            for (int i = 0; i < int'(tbl[v].n) && i <= MAXW; i++)
                words.push_back($urandom);
            run_load(tbl[v].n, tbl[v].delta, tbl[v].maxgap, tbl[v].start_mid,
                     tbl[v].exp_done, tbl[v].exp_words);
        end

        // Reset two bytes into the second word: only word 0 may reach memory
        words.delete();
        words.push_back(32'h11223344);
        words.push_back(32'h55667788);
        pulse_start(1'b1);
        cur_n = 2;
        send(8'h00, 0);
        send(8'h02, 0);
        for (int k = 3; k >= 0; k--)
            send(words[0][8*k +: 8], 0);
        send(8'h55, 0);
        send(8'h66, 0);
        #2 reset = 1'b1;
        #1 check_reset_vals("mid_word_reset");
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_reset_write_count", 64'(got_data.size()), 64'd1);
        words.delete();
        words.push_back(32'h20080005);
        words.push_back(32'h08000000);
        run_load(16'd2, 8'd0, 0, -1, 1'b1, 2);

        for (int it = 0; it < 12; it++) begin
            int r;
            int n;
            int delta;
            int sm;
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = $urandom_range(257, 600);
            else             n = $urandom_range(1, 6);
            delta = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
            words.delete();
            for (int i = 0; i < n && i <= MAXW; i++)
                words.push_back($urandom);
            sm = (n >= 1 && n <= MAXW && $urandom_range(0, 2) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
            run_load(16'(n), 8'(delta), 2, sm, model_done(n, delta), model_words(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: maximum number of words accepted per load.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-005 SHALL have port rx_data, input, 8 bits: incoming byte stream.
REQ-006 SHALL have port rx_valid, input, 1 bit: rx_data is valid this cycle.
REQ-007 SHALL have port rx_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 SHALL have port wr_en, output, 1 bit: instruction-memory write strobe.
REQ-009 SHALL have port wr_addr, output, 32 bits: instruction-memory word index, matching the core's PC+1 word addressing.
REQ-010 SHALL have port wr_data, output, 32 bits: instruction word to write.
REQ-011 SHALL have port core_hold, output, 1 bit: holds the processor in reset while high.
REQ-012 SHALL have ports busy, done and error, each output, 1 bit: load status flags.
REQ-013 SHALL have port words_loaded, output, 16 bits: count of words written in the current or last load.

Function
REQ-014 SHALL accept a byte only on a cycle where rx_valid=1 and rx_ready=1; bytes offered at other times SHALL be ignored.
REQ-015 SHALL implement the states IDLE, HDR, DATA, CHK, DONE and ERR.
REQ-016 IDLE: rx_ready=0 and core_hold=0; start=1 SHALL move to HDR, clear words_loaded, the byte counter and the checksum.
REQ-017 HDR: rx_ready=1; SHALL take two bytes, MSB first, as the word count N (16 bits).
REQ-018 HDR, after the 2nd byte: N=0 or N>MAX_WORDS SHALL move to ERR; otherwise the state SHALL move to DATA.
REQ-019 DATA: rx_ready=1; SHALL shift bytes into the word MSB first (first byte into bits [31:24]).
REQ-020 DATA: every data byte SHALL be added to an 8-bit checksum, modulo 256.
REQ-021 The cycle after the 4th byte of a word is accepted: wr_en=1 for exactly one cycle, wr_addr=words_loaded (value before increment), wr_data=assembled word; words_loaded SHALL increment in the same cycle.
REQ-022 The write cycle SHALL NOT stall byte acceptance: rx_ready remains 1, and the next word's first byte may be accepted in the write cycle.
REQ-023 After the Nth word's 4th byte is accepted, the state SHALL move to CHK; the Nth write strobe SHALL still issue the following cycle.
REQ-024 CHK: rx_ready=1; one byte SHALL be accepted; equal to the checksum -> DONE, not equal -> ERR.
REQ-025 DONE: done=1, core_hold=0, rx_ready=0.
REQ-026 ERR: error=1, core_hold=1, rx_ready=0; writes already performed SHALL NOT be undone.
REQ-027 busy=1 and core_hold=1 in HDR, DATA and CHK.
REQ-028 start SHALL be ignored in HDR, DATA and CHK; start in DONE or ERR SHALL restart at HDR (same clearing as from IDLE) and drop done/error the next cycle.
REQ-029 wr_en SHALL be 0 in every cycle other than a REQ-021 write cycle; wr_addr and wr_data SHALL hold their last values.
REQ-030 All outputs SHALL be registered, except rx_ready, which is decoded from state.

Reset
REQ-031 Assertion of reset, in any state including mid-word, SHALL set: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, words_loaded=0, checksum=0, byte counter=0, busy=0, done=0, error=0, core_hold=0, rx_ready=0.
REQ-032 A partially assembled word SHALL be discarded on reset and SHALL NOT be written.

Verification
REQ-033 Nominal load: start; bytes 00 02 | 20 08 00 05 | 08 00 00 00 | checksum 35 -> writes (0,0x20080005) then (1,0x08000000); done=1; words_loaded=2; core_hold=0.
REQ-034 Bad checksum: same stream as REQ-033 with checksum 36 -> both writes occur; error=1; core_hold=1; done=0.
REQ-035 Bad header: header 00 00, then separately 01 01 with MAX_WORDS=256 -> ERR immediately after the 2nd header byte; no wr_en pulse.
REQ-036 Back-to-back bytes: rx_valid held high for all of REQ-033 -> one byte accepted per cycle; each wr_en one cycle after its 4th byte; no dropped byte.
REQ-037 Mid-word reset: reset asserted after 2 of the 4 bytes of word 1 -> all outputs at reset values; no write for word 1; a fresh start then loads correctly from address 0.
REQ-038 Start while busy: start pulsed during DATA -> ignored; load completes with done=1.
